// File: rtl/encoder_pkg.sv
// Shared types and helpers for the quadrature encoder input path.
//   quad_state_t  : {a, b} pair of filtered channel levels
//   cond_state_t  : conditioner FSM states (INIT waits for the synchronisers, RUN decodes)
//   gray_next()   : successor of a quadrature state when channel A leads channel B
package encoder_pkg;

    typedef logic [1:0] quad_state_t;

    typedef enum logic {
        INIT,
        RUN
    } cond_state_t;

    localparam logic DIR_A_LEADS = 1'b1;
    localparam logic DIR_B_LEADS = 1'b0;

    // A-leads order is 00 -> 10 -> 11 -> 01 -> 00, state packed as {a, b}.
    function automatic quad_state_t gray_next(input quad_state_t s);
        quad_state_t n;
        case (s)
            2'b00:   n = 2'b10;
            2'b10:   n = 2'b11;
            2'b11:   n = 2'b01;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/encoder_input_conditioner_glitch_filter.sv
// Per-channel synchroniser plus persistence filter.
//   clk, reset : clock and synchronous active-high reset
//   raw        : asynchronous pin
//   run        : filter enabled; when low the persistence count is held at zero
//   level      : currently accepted (filtered) level, owned by the parent
//   synced     : output of the synchroniser chain
//   accept     : combinational; the parent must load level <= synced on this edge
module encoder_input_conditioner_glitch_filter #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic run,
    input  logic level,
    output logic synced,
    output logic accept
);

    localparam int unsigned CntW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q, cnt_d;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q  <= cnt_d;
        end
    end

    // A differing level must be seen FILTER_CYCLES times in a row; any match restarts the count.
    always_comb begin
        cnt_d  = '0;
        accept = 1'b0;
        if (run && (synced != level)) begin
            if (cnt_q == CntLast) begin
                accept = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_input_conditioner.sv
// Conditions raw quadrature encoder pins: synchronise, glitch-filter, decode edges.
//   clk, reset         : clock and synchronous active-high reset
//   encoder_a/b        : raw asynchronous channels
//   clear_errors       : synchronous clear of error_count
//   sig_a/b            : filtered channel levels
//   state_change       : 1-cycle strobe, exactly one channel changed
//   direction          : 1 = A leads B, 0 = B leads A; held between edges
//   illegal_transition : 1-cycle strobe, both channels changed on the same edge
//   error_count        : saturating count of illegal transitions
module encoder_input_conditioner
    import encoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned FILTER_CYCLES   = 4,
    parameter int unsigned ERR_COUNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       encoder_a,
    input  logic                       encoder_b,
    input  logic                       clear_errors,
    output logic                       sig_a,
    output logic                       sig_b,
    output logic                       state_change,
    output logic                       direction,
    output logic                       illegal_transition,
    output logic [ERR_COUNT_WIDTH-1:0] error_count
);

    localparam int unsigned InitW = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [InitW-1:0] InitLast = InitW'(SYNC_STAGES);

    cond_state_t                state_q, state_d;
    logic [InitW-1:0]           init_cnt_q, init_cnt_d;
    logic                       sig_a_q, sig_a_d, sig_b_q, sig_b_d;
    logic                       change_q, change_d;
    logic                       dir_q, dir_d;
    logic                       illegal_q, illegal_d;
    logic [ERR_COUNT_WIDTH-1:0] err_q, err_d;
    logic                       synced_a, synced_b, accept_a, accept_b, run;
    quad_state_t                prev_ab, next_ab;

    assign run = (state_q == RUN);

    encoder_input_conditioner_glitch_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter_a (
        .clk   (clk),
        .reset (reset),
        .raw   (encoder_a),
        .run   (run),
        .level (sig_a_q),
        .synced(synced_a),
        .accept(accept_a)
    );

    encoder_input_conditioner_glitch_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter_b (
        .clk   (clk),
        .reset (reset),
        .raw   (encoder_b),
        .run   (run),
        .level (sig_b_q),
        .synced(synced_b),
        .accept(accept_b)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        sig_a_d    = sig_a_q;
        sig_b_d    = sig_b_q;
        change_d   = 1'b0;
        illegal_d  = 1'b0;
        dir_d      = dir_q;
        err_d      = err_q;
        prev_ab    = {sig_a_q, sig_b_q};
        next_ab    = prev_ab;

        case (state_q)
            INIT: begin
                // Preload from the synchronisers so pins already high at power-up make no edge.
                if (init_cnt_q == InitLast) begin
                    sig_a_d    = synced_a;
                    sig_b_d    = synced_b;
                    init_cnt_d = '0;
                    state_d    = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (accept_a) sig_a_d = synced_a;
                if (accept_b) sig_b_d = synced_b;
                next_ab = {sig_a_d, sig_b_d};
                case (prev_ab ^ next_ab)
                    2'b11: illegal_d = 1'b1;
                    2'b01, 2'b10: begin
                        change_d = 1'b1;
                        dir_d    = (next_ab == gray_next(prev_ab)) ? DIR_A_LEADS : DIR_B_LEADS;
                    end
                    default: ;
                endcase
            end
            default: state_d = INIT;
        endcase

        // A clear coinciding with an illegal edge keeps that edge counted.
        if (clear_errors) begin
            err_d = illegal_d ? ERR_COUNT_WIDTH'(1) : '0;
        end else if (illegal_d && !(&err_q)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            sig_a_q    <= 1'b0;
            sig_b_q    <= 1'b0;
            change_q   <= 1'b0;
            dir_q      <= 1'b0;
            illegal_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            sig_a_q    <= sig_a_d;
            sig_b_q    <= sig_b_d;
            change_q   <= change_d;
            dir_q      <= dir_d;
            illegal_q  <= illegal_d;
            err_q      <= err_d;
        end
    end

    assign sig_a              = sig_a_q;
    assign sig_b              = sig_b_q;
    assign state_change       = change_q;
    assign direction          = dir_q;
    assign illegal_transition = illegal_q;
    assign error_count        = err_q;

endmodule

// File: tb/tb_encoder_input_conditioner.sv
// Bench for encoder_input_conditioner at default parameters.
module tb_encoder_input_conditioner;
    import encoder_pkg::*;

    localparam int Latency = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       encoder_a = 1'b1;
    logic       encoder_b = 1'b1;
    logic       clear_errors = 1'b0;
    logic       sig_a, sig_b, state_change, direction, illegal_transition;
    logic [7:0] error_count;

    encoder_input_conditioner dut (
        .clk               (clk),
        .reset             (reset),
        .encoder_a         (encoder_a),
        .encoder_b         (encoder_b),
        .clear_errors      (clear_errors),
        .sig_a             (sig_a),
        .sig_b             (sig_b),
        .state_change      (state_change),
        .direction         (direction),
        .illegal_transition(illegal_transition),
        .error_count       (error_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic a;
        logic b;
        logic exp_sc;
        logic exp_dir;
        logic exp_ill;
    } step_t;

    typedef struct {
        int         due;
        logic       sa;
        logic       sb;
        logic       sc;
        logic       dir;
        logic       ill;
        logic [7:0] err;
    } ev_t;

    ev_t   q[$];
    ev_t   ev;
    step_t steps[10];
    int    errors = 0;
    int    checks = 0;
    bit    mon_on = 1'b0;
    logic  cur_dir = 1'b0;
    int    model_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic a, input logic b, input logic sc, input logic dir,
                        input logic ill);
        ev_t e;
        e.due = cyc + Latency;
        e.sa  = a;
        e.sb  = b;
        e.sc  = sc;
        e.dir = dir;
        e.ill = ill;
        e.err = 8'(model_err);
        q.push_back(e);
    endtask

    // Drive a new pin pair right after an edge, queue its expected effect, hold 20 cycles.
    task automatic drive(input logic a, input logic b, input logic sc, input logic dir,
                         input logic ill);
        tick();
        encoder_a = a;
        encoder_b = b;
        if (ill) model_err = (model_err < 255) ? model_err + 1 : 255;
        push(a, b, sc, dir, ill);
        repeat (19) tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_sig_a"}, sig_a, 0);
        chk({tag, "_sig_b"}, sig_b, 0);
        chk({tag, "_state_change"}, state_change, 0);
        chk({tag, "_illegal"}, illegal_transition, 0);
        chk({tag, "_direction"}, direction, 0);
        chk({tag, "_error_count"}, error_count, 0);
    endtask

    // Scoreboard: each cycle either the next expected event is due, or no strobe may appear.
    always @(negedge clk) begin
        if (mon_on) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                ev = q.pop_front();
                chk("missed_event_due_cycle", 32'(cyc), 32'(ev.due));
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                ev = q.pop_front();
                chk("ev_sig_a", sig_a, ev.sa);
                chk("ev_sig_b", sig_b, ev.sb);
                chk("ev_state_change", state_change, ev.sc);
                chk("ev_illegal", illegal_transition, ev.ill);
                chk("ev_direction", direction, ev.dir);
                chk("ev_error_count", error_count, ev.err);
            end else begin
                chk("idle_state_change", state_change, 0);
                chk("idle_illegal", illegal_transition, 0);
            end
        end
    end

    initial begin
        int n;
        // 11 -> 01 -> 00 brings the pins to 00, then A-leads, then B-leads.
        steps[0] = '{a: 0, b: 1, exp_sc: 1, exp_dir: 1, exp_ill: 0};
        steps[1] = '{a: 0, b: 0, exp_sc: 1, exp_dir: 1, exp_ill: 0};
        steps[2] = '{a: 1, b: 0, exp_sc: 1, exp_dir: 1, exp_ill: 0};
        steps[3] = '{a: 1, b: 1, exp_sc: 1, exp_dir: 1, exp_ill: 0};
        steps[4] = '{a: 0, b: 1, exp_sc: 1, exp_dir: 1, exp_ill: 0};
        steps[5] = '{a: 0, b: 0, exp_sc: 1, exp_dir: 1, exp_ill: 0};
        steps[6] = '{a: 0, b: 1, exp_sc: 1, exp_dir: 0, exp_ill: 0};
        steps[7] = '{a: 1, b: 1, exp_sc: 1, exp_dir: 0, exp_ill: 0};
        steps[8] = '{a: 1, b: 0, exp_sc: 1, exp_dir: 0, exp_ill: 0};
        steps[9] = '{a: 0, b: 0, exp_sc: 1, exp_dir: 0, exp_ill: 0};

        // 1. Reset with pins high, then INIT preloads 11 with no strobe.
        repeat (10) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        tick();
        chk("init_hold_sig_a", sig_a, 0);
        chk("init_hold_sig_b", sig_b, 0);
        tick();
        chk("init_load_sig_a", sig_a, 1);
        chk("init_load_sig_b", sig_b, 1);
        chk("init_load_state_change", state_change, 0);
        mon_on = 1'b1;
        repeat (10) tick();

        // 2./3. Legal gray sequences from the table.
        for (int i = 0; i < 10; i++) begin
            drive(steps[i].a, steps[i].b, steps[i].exp_sc, steps[i].exp_dir, steps[i].exp_ill);
            cur_dir = steps[i].exp_dir;
        end

        // 4. 3-cycle pulse is rejected; 4-cycle pulse passes both edges.
        tick();
        encoder_a = 1'b1;
        repeat (3) tick();
        encoder_a = 1'b0;
        repeat (20) tick();
        chk("short_pulse_sig_a", sig_a, 0);
        encoder_a = 1'b1;
        push(1, 0, 1, 1, 0);
        repeat (4) tick();
        encoder_a = 1'b0;
        push(0, 0, 1, 0, 0);
        cur_dir = 1'b0;
        repeat (20) tick();
        chk("long_pulse_sig_a_after", sig_a, 0);

        // 5. 300 simultaneous toggles, counter saturates.
        for (int i = 0; i < 300; i++) begin
            drive(~encoder_a, ~encoder_b, 0, cur_dir, 1);
        end
        chk("saturated_error_count", error_count, 255);

        // 6a. Clear on the same edge as an illegal transition keeps one count.
        tick();
        encoder_a = 1'b1;
        encoder_b = 1'b1;
        model_err = 1;
        push(1, 1, 0, cur_dir, 1);
        repeat (Latency - 1) tick();
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        chk("clear_with_illegal_count", error_count, 1);
        repeat (10) tick();

        // 6b. Clear alone.
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        model_err = 0;
        chk("clear_alone_count", error_count, 0);
        repeat (5) tick();

        // 6c. Reset while channel A filter is part-way through counting.
        encoder_a = 1'b0;
        n = cyc;
        repeat (4) tick();
        chk("mid_filter_cnt", dut.u_filter_a.cnt_q, 2);
        chk("mid_filter_sig_a", sig_a, 1);
        mon_on = 1'b0;
        reset = 1'b1;
        tick();
        check_all_zero("mid_reset");
        chk("mid_reset_fsm_init", dut.state_q, INIT);
        reset = 1'b0;
        mon_on = 1'b1;
        tick();
        tick();
        chk("reinit_hold_sig_b", sig_b, 0);
        tick();
        chk("reinit_sig_a", sig_a, 0);
        chk("reinit_sig_b", sig_b, 1);
        repeat (20) tick();
        chk("filter_cnt_after_reinit", dut.u_filter_a.cnt_q, 0);

        mon_on = 1'b0;
        chk("scoreboard_drained", 32'(q.size()), 0);
        if (cyc - n < 0) chk("cycle_counter_monotonic", 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
